// File: rtl/axis_record_assembler.sv
// Gathers IN_WIDTH core words into one DATA_WIDTH record for the C2H packer, with an
// assembly register and an output holding register. Optional macro RECORD_SEQ_EN stamps a 16-bit sequence.
module axis_record_assembler #(
    parameter int DATA_WIDTH = 16000,
    parameter int IN_WIDTH   = 512
) (
    input  logic                  m_axis_c2h_aclk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_flush,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_next,
    output logic [7:0]            fill_cnt,
    output logic [31:0]           rec_cnt
);

    // SLOTS must stay at or below 255 so the fill count fits its 8-bit port.
    localparam int SLOTS  = (DATA_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int LAST_W = DATA_WIDTH - (SLOTS - 1) * IN_WIDTH;

    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [7:0]            fill_q, fill_d;
    logic                  asm_full_q, asm_full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic [31:0]           rec_cnt_q, rec_cnt_d;

    logic accept;
    logic flush_take;
    logic move;

`ifdef RECORD_SEQ_EN
    logic [15:0] seq_q, seq_d;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves a latch behind.
        accept       = in_valid && !asm_full_q;
        flush_take   = in_flush && !asm_full_q && ((fill_q != 8'd0) || accept);
        move         = asm_full_q && (!data_valid_q || data_next);

        asm_d        = asm_q;
        fill_d       = fill_q;
        asm_full_d   = asm_full_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        rec_cnt_d    = rec_cnt_q;
`ifdef RECORD_SEQ_EN
        seq_d        = seq_q;
`endif

        if (move) begin
            // in_ready is low whenever a move can happen, so no word competes with it.
            data_d       = asm_q;
`ifdef RECORD_SEQ_EN
            data_d[DATA_WIDTH-1 -: 16] = seq_q;
            seq_d        = seq_q + 16'd1;
`endif
            data_valid_d = 1'b1;
            asm_d        = '0;
            fill_d       = 8'd0;
            asm_full_d   = 1'b0;
            rec_cnt_d    = rec_cnt_q + 32'd1;
        end else begin
            if (data_valid_q && data_next) begin
                data_valid_d = 1'b0;
            end
            if (accept) begin
                for (int s = 0; s < SLOTS - 1; s++) begin
                    if (fill_q == 8'(s)) begin
                        asm_d[s*IN_WIDTH +: IN_WIDTH] = in_data;
                    end
                end
                // The last slot is narrower; the word's upper bits are dropped.
                if (fill_q == 8'(SLOTS - 1)) begin
                    asm_d[DATA_WIDTH-1 -: LAST_W] = in_data[LAST_W-1:0];
                    asm_full_d = 1'b1;
                end
                fill_d = fill_q + 8'd1;
            end
            if (flush_take) begin
                asm_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            // NOTE: the wide assembly and output registers are reset too, because flushed
            // records rely on unwritten slots reading as zero and data must read 0 after reset.
            asm_q        <= '0;
            fill_q       <= 8'd0;
            asm_full_q   <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            rec_cnt_q    <= 32'd0;
`ifdef RECORD_SEQ_EN
            seq_q        <= 16'd0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
            asm_q        <= asm_d;
            fill_q       <= fill_d;
            asm_full_q   <= asm_full_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            rec_cnt_q    <= rec_cnt_d;
`ifdef RECORD_SEQ_EN
            seq_q        <= seq_d;
`endif
        end
    end

    assign in_ready   = !asm_full_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign fill_cnt   = fill_q;
    assign rec_cnt    = rec_cnt_q;

endmodule

// File: tb/tb_axis_record_assembler.sv
// Directed self-checking bench for axis_record_assembler at default widths.
// Define RECORD_SEQ_EN on both RTL and bench to also exercise the sequence stamp.
module tb_axis_record_assembler;

    localparam int DW = 16000;
    localparam int IW = 512;
    localparam int SL = (DW + IW - 1) / IW;
    localparam int LW = DW - (SL - 1) * IW;
`ifdef RECORD_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_flush;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_next;
    logic [7:0]    fill_cnt;
    logic [31:0]   rec_cnt;

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] words [64];
    logic [DW-1:0] exp_rec;

    always #5 clk = ~clk;

    axis_record_assembler #(
        .DATA_WIDTH (DW),
        .IN_WIDTH   (IW)
    ) dut (
        .m_axis_c2h_aclk (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_flush        (in_flush),
        .data            (data),
        .data_valid      (data_valid),
        .data_next       (data_next),
        .fill_cnt        (fill_cnt),
        .rec_cnt         (rec_cnt)
    );

    function automatic logic [IW-1:0] pat_word(input int k);
        logic [31:0] k32;
        k32 = k;
        return {16{k32}};
    endfunction

    // Expected record from words[base .. base+n-1]; unwritten slots are zero.
    function automatic logic [DW-1:0] build_rec(input int base, input int n, input int seq);
        logic [DW-1:0] r;
        logic [IW-1:0] w;
        r = '0;
        for (int i = 0; i < n; i++) begin
            w = words[base + i];
            if (i < SL - 1) r[i*IW +: IW] = w;
            else            r[DW-1 -: LW] = w[LW-1:0];
        end
        if (SEQ_EN) r[DW-1 -: 16] = 16'(seq);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        for (int b = 0; b < 200; b++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_word: in_ready stayed 0 for 200 cycles, expected a slot to open");
    endtask

    task automatic wait_valid(input int budget, input string name);
        for (int b = 0; b < budget; b++) begin
            if (data_valid) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: data_valid still 0 after %0d cycles, expected 1", name, budget);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: low word %h expected 0", data[63:0]); end
        checks++; if (fill_cnt !== 8'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_cnt); end
        checks++; if (rec_cnt !== 32'd0) begin errors++; $display("FAIL reset_rec: got %0d expected 0", rec_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_record();
        int low;
        do_reset();
        data_next = 1'b1;
        for (int k = 0; k < 32; k++) words[k] = pat_word(k);
        for (int k = 0; k < 32; k++) send_word(words[k]);
        exp_rec = build_rec(0, 32, 0);
        low = 0;
        // Cycle after the last accept: assembly full, nothing presented yet.
        if (!in_ready) low++;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL full_dv_early: got %b expected 0", data_valid); end
        checks++; if (fill_cnt !== 8'd32) begin errors++; $display("FAIL full_fill32: got %0d expected 32", fill_cnt); end
        tick();
        if (!in_ready) low++;
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL full_dv: got %b expected 1", data_valid); end
        checks++; if (data[511:0] !== words[0]) begin errors++; $display("FAIL full_slot0: got %h expected %h", data[63:0], words[0][63:0]); end
        checks++; if (data[15983:15872] !== words[31][111:0]) begin errors++; $display("FAIL full_slot31: got %h expected %h", data[15935:15872], words[31][63:0]); end
        checks++; if (data !== exp_rec) begin errors++; $display("FAIL full_record: top %h low %h expected top %h low %h", data[DW-1 -: 64], data[63:0], exp_rec[DW-1 -: 64], exp_rec[63:0]); end
        checks++; if (rec_cnt !== 32'd1) begin errors++; $display("FAIL full_rec: got %0d expected 1", rec_cnt); end
        checks++; if (fill_cnt !== 8'd0) begin errors++; $display("FAIL full_fill0: got %0d expected 0", fill_cnt); end
        tick();
        if (!in_ready) low++;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL full_consumed: data_valid %b expected 0", data_valid); end
        checks++; if (low !== 1) begin errors++; $display("FAIL full_bubble: in_ready low %0d cycles expected 1", low); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] exp2;
        do_reset();
        data_next = 1'b0;
        for (int k = 0; k < 64; k++) words[k] = pat_word(1000 + k);
        for (int k = 0; k < 64; k++) send_word(words[k]);
        exp_rec = build_rec(0, 32, 0);
        exp2    = build_rec(32, 32, 1);
        tick();
        tick();
        tick();
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_dv: got %b expected 1", data_valid); end
        checks++; if (data !== exp_rec) begin errors++; $display("FAIL bp_first: low %h expected %h", data[63:0], exp_rec[63:0]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
        checks++; if (fill_cnt !== 8'd32) begin errors++; $display("FAIL bp_fill: got %0d expected 32", fill_cnt); end
        checks++; if (rec_cnt !== 32'd1) begin errors++; $display("FAIL bp_rec1: got %0d expected 1", rec_cnt); end
        tick();
        tick();
        checks++; if (data !== exp_rec) begin errors++; $display("FAIL bp_stable: low %h expected %h", data[63:0], exp_rec[63:0]); end
        data_next = 1'b1;
        tick();
        data_next = 1'b0;
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_b2b_dv: got %b expected 1", data_valid); end
        checks++; if (data !== exp2) begin errors++; $display("FAIL bp_second: low %h expected %h", data[63:0], exp2[63:0]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
        checks++; if (rec_cnt !== 32'd2) begin errors++; $display("FAIL bp_rec2: got %0d expected 2", rec_cnt); end
        checks++; if (fill_cnt !== 8'd0) begin errors++; $display("FAIL bp_fill0: got %0d expected 0", fill_cnt); end
    endtask

    task automatic test_flush_partial();
        do_reset();
        data_next = 1'b1;
        for (int k = 0; k < 5; k++) words[k] = {64{8'hA5}} ^ IW'(k);
        for (int k = 0; k < 5; k++) send_word(words[k]);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        exp_rec = build_rec(0, 5, 0);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL flush_dv_early: got %b expected 0", data_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL flush_dv: got %b expected 1", data_valid); end
        checks++; if (data[2559:0] !== exp_rec[2559:0]) begin errors++; $display("FAIL flush_words: low %h expected %h", data[63:0], exp_rec[63:0]); end
        checks++; if (data[DW-1:2560] !== exp_rec[DW-1:2560]) begin errors++; $display("FAIL flush_pad: bits %h expected %h", data[2623:2560], exp_rec[2623:2560]); end
        checks++; if (fill_cnt !== 8'd0) begin errors++; $display("FAIL flush_fill: got %0d expected 0", fill_cnt); end
        checks++; if (rec_cnt !== 32'd1) begin errors++; $display("FAIL flush_rec: got %0d expected 1", rec_cnt); end
    endtask

    task automatic test_flush_empty();
        tick();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        tick();
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL empty_dv: got %b expected 0", data_valid); end
        checks++; if (rec_cnt !== 32'd1) begin errors++; $display("FAIL empty_rec: got %0d expected 1", rec_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush_coincident();
        for (int k = 0; k < 4; k++) words[k] = pat_word(50 + k);
        for (int k = 0; k < 3; k++) send_word(words[k]);
        in_valid = 1'b1;
        in_data  = words[3];
        in_flush = 1'b1;
        tick();
        in_valid = 1'b0;
        in_flush = 1'b0;
        checks++; if (fill_cnt !== 8'd4) begin errors++; $display("FAIL coinc_fill: got %0d expected 4", fill_cnt); end
        tick();
        exp_rec = build_rec(0, 4, 1);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL coinc_dv: got %b expected 1", data_valid); end
        checks++; if (data !== exp_rec) begin errors++; $display("FAIL coinc_record: slot3 %h expected %h", data[1599:1536], exp_rec[1599:1536]); end
        checks++; if (rec_cnt !== 32'd2) begin errors++; $display("FAIL coinc_rec: got %0d expected 2", rec_cnt); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        data_next = 1'b0;
        for (int k = 0; k < 42; k++) words[k] = pat_word(300 + k);
        for (int k = 0; k < 32; k++) send_word(words[k]);
        wait_valid(5, "midop_first");
        for (int k = 32; k < 42; k++) send_word(words[k]);
        checks++; if (fill_cnt !== 8'd10) begin errors++; $display("FAIL midop_fill10: got %0d expected 10", fill_cnt); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL midop_dv_held: got %b expected 1", data_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL midop_dv: got %b expected 0", data_valid); end
        checks++; if (fill_cnt !== 8'd0) begin errors++; $display("FAIL midop_fill: got %0d expected 0", fill_cnt); end
        checks++; if (rec_cnt !== 32'd0) begin errors++; $display("FAIL midop_rec: got %0d expected 0", rec_cnt); end
        checks++; if (data !== '0) begin errors++; $display("FAIL midop_data: low %h expected 0", data[63:0]); end
        data_next = 1'b1;
        for (int k = 0; k < 32; k++) words[k] = pat_word(500 + k);
        for (int k = 0; k < 32; k++) send_word(words[k]);
        wait_valid(5, "midop_clean");
        exp_rec = build_rec(0, 32, 0);
        checks++; if (data !== exp_rec) begin errors++; $display("FAIL midop_clean: low %h expected %h", data[63:0], exp_rec[63:0]); end
        checks++; if (rec_cnt !== 32'd1) begin errors++; $display("FAIL midop_rec1: got %0d expected 1", rec_cnt); end
    endtask

`ifdef RECORD_SEQ_EN
    task automatic test_seq();
        logic [15:0] exp_seq [5];
        exp_seq[0] = 16'h0000;
        exp_seq[1] = 16'h0001;
        exp_seq[2] = 16'h0002;
        exp_seq[3] = 16'hFFFF;
        exp_seq[4] = 16'h0000;
        do_reset();
        data_next = 1'b1;
        for (int r = 0; r < 5; r++) begin
            if (r == 3) begin
                force dut.seq_q = 16'hFFFF;
                tick();
                release dut.seq_q;
            end
            for (int k = 0; k < 32; k++) send_word(pat_word(600 + r * 32 + k));
            wait_valid(5, "seq_wait");
            checks++;
            if (data[DW-1 -: 16] !== exp_seq[r]) begin
                errors++;
                $display("FAIL seq_stamp%0d: got %h expected %h", r, data[DW-1 -: 16], exp_seq[r]);
            end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        in_data   = '0;
        data_next = 1'b0;
        tick();
        test_reset();
        test_full_record();
        test_back_pressure();
        test_flush_partial();
        test_flush_empty();
        test_flush_coincident();
        test_reset_midop();
`ifdef RECORD_SEQ_EN
        test_seq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
